decode_stage: RTL
=================

# decode_stage

Parametrised instruction-decode stage for the RV32 pipeline, sitting between fetch and execute. Decodes RV32I/RV32E instructions, reads an internal register file with write-back bypass, and holds the decoded result in a registered ID/EX slot. The slot uses a valid/ready handshake on both sides and supports flush. It detects load-use hazards and inserts a bubble on its own.

## Interface
Parameters:
- XLEN, 32, datapath width; 32 only in this generation, checked at elaboration.
- NREGS, 32, architectural register count. Legal values are 32 (RV32I) or 16 (RV32E).
- WB_BYPASS, 1, when 1 a same-cycle write-back is forwarded to the read ports.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock, rising edge.
  - rst_n  in  1  async active-low reset.
- Fetch side:
  - in_valid  in  1  fetch presents an instruction.
  - in_ready  out  1  stage accepts the instruction this cycle.
  - in_instr  in  32  instruction word.
  - in_pc  in  XLEN  PC of in_instr.
- Control and write-back:
  - flush  in  1  kill the held entry and the incoming instruction.
  - wb_we  in  1  write-back enable.
  - wb_rd  in  5  write-back destination.
  - wb_data  in  XLEN  write-back value.
- Execute side:
  - out_valid  out  1  ID/EX slot holds a valid instruction.
  - out_ready  in  1  execute consumes the slot this cycle.
- Registered decoded fields, all out:
  - out_pc, out_pcplus4, out_rd1, out_rd2, out_imm: XLEN each.
  - out_rs1, out_rs2, out_rd: 5 each.
  - out_regwrite, out_memwrite, out_memread, out_jump, out_branch, out_alusrc, out_illegal: 1 each.
  - out_resultsrc: 2.
  - out_alucontrol: 4.

## Operation
- **Decode (combinational from in_instr):**
  - Opcode classes: R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - Immediate formats: I, S, B, J, U, each sign-extended or shifted per the RISC-V spec.
  - alucontrol encoding: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 pass-B (LUI).
  - resultsrc encoding: 0 ALU, 1 mem, 2 pc+4.
- **Illegal instructions:** an unknown opcode, funct3 or funct7 is illegal. When NREGS=16, any rs1/rs2/rd ≥16 is also illegal. An illegal instruction sets out_illegal=1 and forces regwrite, memwrite, memread, jump and branch to 0. It still occupies the slot.
- **Register file:**
  - NREGS×XLEN entries, all reset to 0.
  - Writes occur on clk when wb_we=1 and wb_rd≠0.
  - x0 always reads 0.
  - With WB_BYPASS=1, a read whose address equals wb_rd while wb_we=1 and wb_rd≠0 returns wb_data in the same cycle.
- **Load-use hazard:** hazard = out_valid & out_memread & out_rd≠0 & in_valid & ((uses_rs1 & rs1==out_rd) | (uses_rs2 & rs2==out_rd)). uses_rs1 and uses_rs2 come from the opcode class; LUI, AUIPC and JAL use neither.
- **Handshake:**
  - in_ready = ~hazard & (~out_valid | out_ready), or 1 when flush=1.
  - Accept = in_valid & in_ready & ~flush. On accept the slot loads the decoded fields and out_valid becomes 1.
  - If out_ready=1 with no accept, the slot empties: out_valid becomes 0 (a bubble) and the fields hold their values.
  - With hazard=1 and out_ready=1, the load leaves and a bubble enters. The dependent instruction is accepted on a later cycle.
  - While out_valid=1 & out_ready=0, all out_* fields stay stable.
- **Flush:**
  - Highest priority. Next cycle out_valid=0.
  - The incoming instruction is discarded; in_ready=1 so fetch drops it.
  - The register-file write still occurs.
- **Reset mid-operation:** all outputs and the register file return to 0 immediately (asynchronous), and any pending entry is lost.

## Timing
- Reset values:
  - out_valid=0 and every out_* field 0.
  - in_ready=1 once rst_n is high.
- Latency:
  - 1 cycle from accept to out_valid.
  - Throughput 1 instruction per cycle when out_ready stays high.
- A load followed by a dependent instruction incurs exactly 1 bubble cycle.
- A write-back and a read of the same register in the same cycle return the new value when WB_BYPASS=1 and the old value when WB_BYPASS=0.
- Simultaneous flush and hazard: flush wins, in_ready=1, slot empty next cycle.

## Test plan
- **Reset and basic decode:** reset, then send ADDI x5,x0,-3 (0xFFD00293) at pc=0x100 with out_ready=1. Next cycle: out_valid=1, out_imm=0xFFFFFFFD, out_rd=5, out_alucontrol=0, out_alusrc=1, out_regwrite=1, out_pcplus4=0x104.
- **Bypass:** wb_we=1, wb_rd=7, wb_data=0xDEADBEEF in the same cycle as ADD x1,x7,x0 is accepted. Requires out_rd1=0xDEADBEEF with WB_BYPASS=1, and 0 with WB_BYPASS=0.
- **Load-use:** send LW x3,0(x2), then ADD x4,x3,x3, with out_ready=1.
  - in_ready=0 for exactly one cycle.
  - out_valid sequence is 1,0,1.
  - No bubble when the second instruction is ADD x4,x5,x6.
- **Backpressure:** hold out_ready=0 for 3 cycles with the slot full. Requires in_ready=0 and out_* unchanged. Release gives one transfer per cycle after that.
- **Flush:** assert flush with the slot full and in_valid=1. Next cycle out_valid=0, and the register-file write in the flush cycle is still visible on a later read.
- **RV32E / illegal:** with NREGS=16, ADD x17,x1,x2 gives out_illegal=1 and out_regwrite=0. Opcode 0x7F gives out_illegal=1 in both configurations.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I/RV32E instruction-decode stage: combinational decode, register file
// with optional write-back bypass, and a registered ID/EX slot with
// valid/ready handshake, flush and load-use bubble insertion.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pcplus4,
  output logic [XLEN-1:0] out_rd1,
  output logic [XLEN-1:0] out_rd2,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_regwrite,
  output logic            out_memwrite,
  output logic            out_memread,
  output logic            out_jump,
  output logic            out_branch,
  output logic            out_alusrc,
  output logic            out_illegal,
  output logic [1:0]      out_resultsrc,
  output logic [3:0]      out_alucontrol
);

  localparam int AW = (NREGS == 16) ? 4 : 5;

  generate
    if (XLEN != 32) begin : g_xlen_chk
      $error("decode_stage: XLEN must be 32");
    end
    if (NREGS != 32 && NREGS != 16) begin : g_nregs_chk
      $error("decode_stage: NREGS must be 32 or 16");
    end
  endgenerate

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign rd     = in_instr[11:7];

  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};

  logic        d_regwrite, d_memwrite, d_memread, d_jump, d_branch, d_alusrc;
  logic        d_bad, uses_rs1, uses_rs2, d_illegal, reg_bad;
  logic [1:0]  d_resultsrc;
  logic [3:0]  d_alu;
  logic [31:0] d_imm;

  // Opcode-class decode: control bits, immediate, operand usage, legality.
  always_comb begin
    d_regwrite  = 1'b0;
    d_memwrite  = 1'b0;
    d_memread   = 1'b0;
    d_jump      = 1'b0;
    d_branch    = 1'b0;
    d_alusrc    = 1'b0;
    d_bad       = 1'b0;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    d_resultsrc = 2'd0;
    d_alu       = ALU_ADD;
    d_imm       = 32'd0;
    case (opcode)
      OP_R: begin
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        d_regwrite = 1'b1;
        case (funct3)
          3'b000: if (funct7 == 7'h00) d_alu = ALU_ADD;
                  else if (funct7 == 7'h20) d_alu = ALU_SUB;
                  else d_bad = 1'b1;
          3'b101: if (funct7 == 7'h00) d_alu = ALU_SRL;
                  else if (funct7 == 7'h20) d_alu = ALU_SRA;
                  else d_bad = 1'b1;
          default: begin
            d_bad = (funct7 != 7'h00);
            case (funct3)
              3'b001:  d_alu = ALU_SLL;
              3'b010:  d_alu = ALU_SLT;
              3'b011:  d_alu = ALU_SLTU;
              3'b100:  d_alu = ALU_XOR;
              3'b110:  d_alu = ALU_OR;
              default: d_alu = ALU_AND;
            endcase
          end
        endcase
      end
      OP_I: begin
        uses_rs1   = 1'b1;
        d_regwrite = 1'b1;
        d_alusrc   = 1'b1;
        d_imm      = imm_i;
        case (funct3)
          3'b000:  d_alu = ALU_ADD;
          3'b010:  d_alu = ALU_SLT;
          3'b011:  d_alu = ALU_SLTU;
          3'b100:  d_alu = ALU_XOR;
          3'b110:  d_alu = ALU_OR;
          3'b111:  d_alu = ALU_AND;
          3'b001: if (funct7 == 7'h00) d_alu = ALU_SLL;
                  else d_bad = 1'b1;
          default: if (funct7 == 7'h00) d_alu = ALU_SRL;
                   else if (funct7 == 7'h20) d_alu = ALU_SRA;
                   else d_bad = 1'b1;
        endcase
      end
      OP_LOAD: begin
        uses_rs1    = 1'b1;
        d_regwrite  = 1'b1;
        d_memread   = 1'b1;
        d_alusrc    = 1'b1;
        d_resultsrc = 2'd1;
        d_imm       = imm_i;
        d_bad       = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_STORE: begin
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        d_memwrite = 1'b1;
        d_alusrc   = 1'b1;
        d_imm      = imm_s;
        d_bad      = funct3[2] || (funct3 == 3'b011);
      end
      OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        d_branch = 1'b1;
        d_imm    = imm_b;
        d_bad    = (funct3 == 3'b010) || (funct3 == 3'b011);
        case (funct3[2:1])
          2'b10:   d_alu = ALU_SLT;
          2'b11:   d_alu = ALU_SLTU;
          default: d_alu = ALU_SUB;
        endcase
      end
      OP_JAL: begin
        d_regwrite  = 1'b1;
        d_jump      = 1'b1;
        d_resultsrc = 2'd2;
        d_imm       = imm_j;
      end
      OP_JALR: begin
        uses_rs1    = 1'b1;
        d_regwrite  = 1'b1;
        d_jump      = 1'b1;
        d_alusrc    = 1'b1;
        d_resultsrc = 2'd2;
        d_imm       = imm_i;
        d_bad       = (funct3 != 3'b000);
      end
      OP_LUI: begin
        d_regwrite = 1'b1;
        d_alusrc   = 1'b1;
        d_alu      = ALU_PASSB;
        d_imm      = imm_u;
      end
      OP_AUIPC: begin
        d_regwrite = 1'b1;
        d_alusrc   = 1'b1;
        d_imm      = imm_u;
      end
      default: d_bad = 1'b1;
    endcase
  end

  // RV32E only checks register fields the instruction actually uses.
  assign reg_bad   = (NREGS == 16) &&
                     ((uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]) || (d_regwrite && rd[4]));
  assign d_illegal = d_bad || reg_bad;

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic            wr_en;

  function automatic logic in_range(input logic [4:0] a);
    return ({1'b0, a} < 6'(NREGS));
  endfunction

  assign wr_en  = wb_we && (wb_rd != 5'd0) && in_range(wb_rd);
  assign rf_rd1 = ((rs1 == 5'd0) || !in_range(rs1)) ? '0 :
                  (WB_BYPASS && wr_en && (wb_rd == rs1)) ? wb_data : regs[rs1[AW-1:0]];
  assign rf_rd2 = ((rs2 == 5'd0) || !in_range(rs2)) ? '0 :
                  (WB_BYPASS && wr_en && (wb_rd == rs2)) ? wb_data : regs[rs2[AW-1:0]];

  // Register file write port; flush does not suppress write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wb_rd[AW-1:0]] <= wb_data;
    end
  end

  logic hazard, accept;

  assign hazard = out_valid && out_memread && (out_rd != 5'd0) && in_valid &&
                  ((uses_rs1 && (rs1 == out_rd)) || (uses_rs2 && (rs2 == out_rd)));
  assign in_ready = flush || (!hazard && (!out_valid || out_ready));
  assign accept   = in_valid && in_ready && !flush;

  // ID/EX slot: flush clears valid, accept loads, consume without accept bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_pcplus4    <= '0;
      out_rd1        <= '0;
      out_rd2        <= '0;
      out_imm        <= '0;
      out_rs1        <= '0;
      out_rs2        <= '0;
      out_rd         <= '0;
      out_regwrite   <= 1'b0;
      out_memwrite   <= 1'b0;
      out_memread    <= 1'b0;
      out_jump       <= 1'b0;
      out_branch     <= 1'b0;
      out_alusrc     <= 1'b0;
      out_illegal    <= 1'b0;
      out_resultsrc  <= '0;
      out_alucontrol <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_pc         <= in_pc;
      out_pcplus4    <= in_pc + XLEN'(4);
      out_rd1        <= rf_rd1;
      out_rd2        <= rf_rd2;
      out_imm        <= d_imm;
      out_rs1        <= rs1;
      out_rs2        <= rs2;
      out_rd         <= rd;
      out_regwrite   <= d_regwrite && !d_illegal;
      out_memwrite   <= d_memwrite && !d_illegal;
      out_memread    <= d_memread && !d_illegal;
      out_jump       <= d_jump && !d_illegal;
      out_branch     <= d_branch && !d_illegal;
      out_alusrc     <= d_alusrc;
      out_illegal    <= d_illegal;
      out_resultsrc  <= d_resultsrc;
      out_alucontrol <= d_alu;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
